out_display_driver: RTL
=======================

Name: out_display_driver

Overview:
- Downstream consumer of the machine's output register value.
- Converts the 8-bit value to decimal, unsigned or two's-complement, using a sequential double-dabble engine.
- Drives a multiplexed 4-digit common-cathode 7-segment display, the same style as the hand-built board's output module.

Parameters:
- SCAN_DIV, 1024: clk cycles each digit stays enabled. Minimum 2. Benches use 4.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- value, input, 8: output-register value to display.
- signed_mode, input, 1: 1 = interpret value as two's complement.
- seg, output, 7: segments, active-high; seg[0]=a … seg[6]=g.
- digit_en, output, 4: one-hot digit enable. Bit 0 = ones, 1 = tens, 2 = hundreds, 3 = sign.
- bcd, output, 12: latched decimal magnitude {hundreds, tens, ones}.
- negative, output, 1: latched sign of the displayed number.
- busy, output, 1: conversion in progress.

Behaviour:
- Reset: synchronous, active-high; clock clk.
  - State IDLE; captured {signed_mode, value} = 0; bcd = 0; negative = 0; busy = 0.
  - Scan counter = 0, digit index = 0, digit_en = 4'b0001, seg = 7'h3F (digit "0").
- Reset mid-conversion aborts the conversion; no partial result is written.
- Conversion FSM, states IDLE and CONV:
  - IDLE: if {signed_mode, value} differs from captured, on that edge:
    - capture the pair;
    - magnitude = (signed_mode & value[7]) ? (~value + 1) : value, 8-bit unsigned, so 8'h80 signed gives 128;
    - sign = signed_mode & value[7];
    - clear the 12-bit scratch, set the iteration counter to 0, go to CONV, busy = 1.
  - CONV: each cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, magnitude} left 1. Counter increments.
  - On the edge where counter = 7 (8th shift): bcd and negative are written from the final scratch and sign; return to IDLE; busy = 0.
- Latency: a value change sampled at edge N gives busy = 1 after N. The new bcd/negative are visible after edge N+8.
- Input changes during CONV are ignored. They are compared again in IDLE, so the last stable input is always displayed eventually, one extra cycle after the prior result.
- Scan:
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index increments mod 4.
  - seg and digit_en are registered and update on the same edge as the index, so there are no glitches between digits.
  - seg for index k is computed from the current bcd/negative.
- Digit content:
  - Ones: always shown.
  - Tens: blank when hundreds = 0 and tens = 0.
  - Hundreds: blank when 0.
  - Sign: 7'h40 (segment g) when negative, else blank (7'h00).
- Glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- A BCD nibble above 9 is unreachable. If it occurs, it is encoded blank.

Decomposition:
- Shared package:
  - state enum {IDLE, CONV};
  - glyph constants SEG_DIGIT[0:9], SEG_BLANK, SEG_MINUS;
  - digit index constants DIG_ONES, DIG_TENS, DIG_HUND, DIG_SIGN.
- One sub-module, seg7_encode: combinational 4-bit nibble plus blank input → 7-bit glyph. It is instantiated once on the muxed nibble.
- The FSM and the scan logic stay in the top module.

Test Plan:
- Reset with value = 0, SCAN_DIV = 4:
  - busy stays 0; bcd = 12'h000; digit_en = 0001, seg = 3F.
  - After 4 clks digit_en = 0010 and seg = 00 (blank tens); the sequence wraps after 16 clks.
- value = 237, signed_mode = 0:
  - busy high for exactly 8 cycles; bcd = 12'h237, negative = 0.
  - Scan shows ones = 07, tens = 4F, hundreds = 5B, sign = 00.
- signed_mode = 1, value = 8'hFB:
  - bcd = 12'h005, negative = 1.
  - Scan shows 6D, 00, 00, 40.
- signed_mode = 1, value = 8'h80: bcd = 12'h128, negative = 1, sign digit = 40.
- value = 10, then 200 on the 3rd busy cycle:
  - bcd = 12'h010 after the first conversion;
  - busy re-asserts the next cycle;
  - bcd = 12'h200 after 8 more cycles.
- Reset asserted on the 5th busy cycle of converting 99:
  - next cycle busy = 0, bcd = 0, digit_en = 0001;
  - with value still 99 after release, conversion restarts and bcd = 12'h099.

Source files
------------

// File: rtl/out_display_driver_pkg.sv
// rtl/out_display_driver_pkg.sv - shared types, glyphs and helpers for the output display driver
package out_display_driver_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Common-cathode glyphs, seg[0]=a .. seg[6]=g
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;
    localparam logic [1:0] DIG_SIGN = 2'd3;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift
    function automatic logic [11:0] dd_adjust(input logic [11:0] s);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/out_display_driver_if.sv
// rtl/out_display_driver_if.sv - value input and display/status outputs of the display driver
// master: producer of the output-register value (drives value, signed_mode)
// slave : the display driver (drives seg, digit_en, bcd, negative, busy)
interface out_display_driver_if;
    logic [7:0]  value;
    logic        signed_mode;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic [11:0] bcd;
    logic        negative;
    logic        busy;

    modport master (
        output value, signed_mode,
        input  seg, digit_en, bcd, negative, busy
    );

    modport slave (
        input  value, signed_mode,
        output seg, digit_en, bcd, negative, busy
    );
endinterface

// File: rtl/out_display_driver_seg7_encode.sv
// rtl/out_display_driver_seg7_encode.sv - BCD nibble to 7-segment glyph, with blanking
// nibble: BCD digit; blank: force all segments off; glyph: active-high segments
module seg7_encode
    import out_display_driver_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph
);
    always_comb begin
        glyph = SEG_BLANK;
        // Nibbles above 9 cannot come out of the converter; show them blank
        if (!blank && nibble <= 4'd9) begin
            glyph = SEG_DIGIT[nibble];
        end
    end
endmodule

// File: rtl/out_display_driver.sv
// rtl/out_display_driver.sv - 8-bit value to decimal, multiplexed onto a 4-digit 7-segment display
// clk, reset (sync, active-high); dif (slave): value/signed_mode in,
// seg/digit_en scan outputs, bcd/negative latched result, busy during conversion
module out_display_driver
    import out_display_driver_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    out_display_driver_if.slave  dif
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_t      state, state_next;
    logic [8:0]  cap_q;
    logic [11:0] scratch_q;
    logic [7:0]  mag_q;
    logic        sign_q;
    logic [2:0]  iter_q;
    logic [11:0] bcd_q;
    logic        neg_q;

    logic [8:0]  in_pair;
    logic        in_neg;
    logic [7:0]  in_mag;
    logic [11:0] scratch_adj;
    logic [11:0] scratch_shift;

    assign in_pair       = {dif.signed_mode, dif.value};
    assign in_neg        = dif.signed_mode & dif.value[7];
    assign in_mag        = in_neg ? (~dif.value + 8'd1) : dif.value;
    assign scratch_adj   = dd_adjust(scratch_q);
    assign scratch_shift = {scratch_adj[10:0], mag_q[7]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_pair != cap_q) state_next = CONV;
            CONV: if (iter_q == 3'd7)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q     <= '0;
            scratch_q <= '0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            iter_q    <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else if (state == IDLE) begin
            if (in_pair != cap_q) begin
                cap_q     <= in_pair;
                mag_q     <= in_mag;
                sign_q    <= in_neg;
                scratch_q <= '0;
                iter_q    <= '0;
            end
        end else begin
            scratch_q <= scratch_shift;
            mag_q     <= {mag_q[6:0], 1'b0};
            iter_q    <= iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                bcd_q <= scratch_shift;
                neg_q <= sign_q;
            end
        end
    end

    assign dif.busy     = (state == CONV);
    assign dif.bcd      = bcd_q;
    assign dif.negative = neg_q;

    // Scan: seg/digit_en are registered together with the index so digits never glitch
    logic [CW-1:0] scan_cnt;
    logic [1:0]    dig_idx;
    logic [1:0]    idx_next;
    logic [3:0]    nib;
    logic          nib_blank;
    logic [6:0]    glyph;
    logic [6:0]    seg_next;

    assign idx_next = dig_idx + 2'd1;

    always_comb begin
        nib       = 4'd0;
        nib_blank = 1'b1;
        case (idx_next)
            DIG_ONES: begin nib = bcd_q[3:0];  nib_blank = 1'b0; end
            DIG_TENS: begin nib = bcd_q[7:4];  nib_blank = (bcd_q[11:4] == 8'd0); end
            DIG_HUND: begin nib = bcd_q[11:8]; nib_blank = (bcd_q[11:8] == 4'd0); end
            default:  begin nib = 4'd0;        nib_blank = 1'b1; end
        endcase
    end

    seg7_encode u_enc (
        .nibble (nib),
        .blank  (nib_blank),
        .glyph  (glyph)
    );

    assign seg_next = (idx_next == DIG_SIGN) ? (neg_q ? SEG_MINUS : SEG_BLANK) : glyph;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt     <= '0;
            dig_idx      <= DIG_ONES;
            dif.digit_en <= 4'b0001;
            dif.seg      <= SEG_DIGIT[0];
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt     <= '0;
            dig_idx      <= idx_next;
            dif.digit_en <= 4'b0001 << idx_next;
            dif.seg      <= seg_next;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end
endmodule
